// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-side AXI read bridge: FSM encoding,
// cache request types and the fixed AXI burst parameters.
package cache_axi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_AR   = 4'b0010,
        ST_R    = 4'b0100,
        ST_RET  = 4'b1000
    } state_t;

    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [7:0] LEN_LINE   = 8'd3;

    // Line requests are flagged by bit 2 of rd_type; the low bits give the size.
    function automatic logic is_line(input logic [2:0] rd_type);
        return rd_type[2];
    endfunction

endpackage

// File: rtl/cache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the bridge (master)
// and the crossbar port (slave).
interface cache_axi_rd_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/cache_axi_rd_bridge.sv
// Cache miss read responder: one request at a time becomes one AXI read burst,
// whose beats are packed into a 128-bit line returned as a single-cycle pulse.
module cache_axi_rd_bridge
    import cache_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [2:0]            rd_type,
    input  logic [31:0]           rd_addr,
    output logic                  rd_rdy,
    output logic                  ret_valid,
    output logic [127:0]          ret_data,
    cache_axi_rd_bridge_if.master axi
);

    state_t       state;
    logic [1:0]   beat_cnt;
    logic [127:0] line_q;

    // Response ID and status are deliberately not inspected.
    logic unused_r_fields;
    assign unused_r_fields = ^{axi.rid, axi.rresp};

    assign axi.arid    = AXI_ID;
    assign axi.arburst = BURST_INCR;
    assign ret_data    = line_q;

    // NOTE: every register here uses <= so all updates take effect together at
    // the edge, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_rdy     <= 1'b1;
            axi.arvalid <= 1'b0;
            axi.rready <= 1'b0;
            ret_valid  <= 1'b0;
            axi.araddr <= '0;
            axi.arlen  <= '0;
            axi.arsize <= '0;
            beat_cnt   <= '0;
            // NOTE: the line register is reset because ret_data is observable
            // straight from it and must read zero out of reset.
            line_q     <= '0;
        end else begin
            ret_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        state       <= ST_AR;
                        rd_rdy      <= 1'b0;
                        axi.arvalid <= 1'b1;
                        line_q      <= '0;
                        if (is_line(rd_type)) begin
                            axi.araddr <= {rd_addr[31:4], 4'b0000};
                            axi.arlen  <= LEN_LINE;
                            axi.arsize <= SIZE_4B;
                        end else begin
                            axi.araddr <= rd_addr;
                            axi.arlen  <= 8'd0;
                            axi.arsize <= {1'b0, rd_type[1:0]};
                        end
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        state       <= ST_R;
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        beat_cnt    <= 2'd0;
                    end
                end
                ST_R: begin
                    if (axi.rvalid) begin
                        line_q[{beat_cnt, 5'd0} +: 32] <= axi.rdata;
                        // Saturate so surplus beats land in the last slot.
                        if (beat_cnt != 2'd3) begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                        if (axi.rlast) begin
                            state      <= ST_RET;
                            axi.rready <= 1'b0;
                            ret_valid  <= 1'b1;
                        end
                    end
                end
                ST_RET: begin
                    state  <= ST_IDLE;
                    rd_rdy <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    rd_rdy      <= 1'b1;
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
